// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, frame
// classification and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld
    } state_e;

    typedef enum logic [1:0] {
        FrNone,
        FrSingle,
        FrMulti
    } frame_e;

    typedef struct packed {
        frame_e     kind;
        logic [3:0] idx;
    } frame_res_t;

    // Indexed {row, col}; rows 0..3 top to bottom, cols 0..3 left to right.
    localparam logic [3:0] KeyMap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Counts pressed keys in a frame (saturating at 2) and reports the
    // position of the pressed key when exactly one is down.
    function automatic frame_res_t classify(input logic [15:0] mat);
        frame_res_t res;
        logic [1:0] hits;
        res.idx = '0;
        hits    = '0;
        for (int i = 0; i < 16; i++) begin
            if (mat[i]) begin
                res.idx = 4'(i);
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
            end
        end
        case (hits)
            2'd0:    res.kind = FrNone;
            2'd1:    res.kind = FrSingle;
            default: res.kind = FrMulti;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column slot timer: counts SCAN_DIV cycles per slot and steps the active
// column index 0..3, flagging the last cycle of each slot and of each frame.
module scan_timer #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       slot_end,
    output logic       frame_end,
    output logic [1:0] col_idx
);
    import keypad_pkg::*;

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CntW-1:0] slot_cnt_q;
    logic [1:0]      col_idx_q;

    assign slot_end  = (slot_cnt_q == CntW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (col_idx_q == 2'd3);
    assign col_idx   = col_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            col_idx_q  <= 2'd0;
        end else if (slot_end) begin
            slot_cnt_q <= '0;
            col_idx_q  <= col_idx_q + 2'd1;
        end else begin
            slot_cnt_q <= slot_cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner and debouncer: drives one column low at a time,
// builds a per-frame key matrix and emits one key_en pulse per accepted press.
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 20000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_en,
    output logic [3:0] key_code,
    output logic       key_held
);
    import keypad_pkg::*;

    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [3:0]      row_meta_q;
    logic [3:0]      row_sync_q;
    logic [15:0]     matrix_q;
    logic [15:0]     frame_mat;
    logic [3:0]      col_q;
    logic            slot_end;
    logic            frame_end;
    logic [1:0]      col_idx;
    frame_res_t      frame_res;
    logic [3:0]      fr_code;
    state_e          state_q;
    logic [3:0]      cand_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    logic            count_done;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .col_idx   (col_idx)
    );

    // Rows are asynchronous to clk; released (all ones) out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // The column being sampled this cycle is merged in so the frame-end
    // classification sees all four columns without an extra cycle of delay.
    always_comb begin
        frame_mat = matrix_q;
        for (int r = 0; r < 4; r++) begin
            frame_mat[r * 4 + int'(col_idx)] = ~row_sync_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_q <= '0;
            col_q    <= 4'b1110;
        end else if (slot_end) begin
            matrix_q <= frame_mat;
            col_q    <= ~(4'b0001 << (col_idx + 2'd1));
        end
    end

    assign col       = col_q;
    assign frame_res = classify(frame_mat);
    assign fr_code   = KeyMap[frame_res.idx];

    assign count_done = (cnt_q >= CntW'(DEBOUNCE_FRAMES - 1));
    assign cnt_inc    = (cnt_q == CntW'(DEBOUNCE_FRAMES)) ? cnt_q : cnt_q + CntW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cand_q   <= '0;
            cnt_q    <= '0;
            key_en   <= 1'b0;
            key_code <= '0;
            key_held <= 1'b0;
        end else begin
            key_en <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    StIdle: begin
                        if (frame_res.kind == FrSingle) begin
                            if (DEBOUNCE_FRAMES <= 1) begin
                                key_code <= fr_code;
                                key_en   <= 1'b1;
                                key_held <= 1'b1;
                                state_q  <= StHeld;
                                cnt_q    <= '0;
                            end else begin
                                cand_q  <= fr_code;
                                cnt_q   <= CntW'(1);
                                state_q <= StDebounce;
                            end
                        end
                    end
                    StDebounce: begin
                        if (frame_res.kind == FrSingle && fr_code == cand_q) begin
                            if (count_done) begin
                                key_code <= cand_q;
                                key_en   <= 1'b1;
                                key_held <= 1'b1;
                                state_q  <= StHeld;
                                cnt_q    <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end
                    end
                    StHeld: begin
                        // Any key activity restarts the release count; no repeat.
                        if (frame_res.kind == FrNone) begin
                            if (count_done) begin
                                state_q  <= StIdle;
                                cnt_q    <= '0;
                                key_held <= 1'b0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix-keypad scanner and debouncer that sits directly upstream of the calculator core. It drives one keypad column at a time and samples the rows. After a key has been stable for a set number of scan frames, it emits exactly one single-cycle `key_en` pulse and a 4-bit `key_code`. Codes 0–9 are digits; A/B/C/D are + − × ÷; E/F are spare codes that the system top maps to `equal`/`save`.

## Interface
- `SCAN_DIV`, 20000: clock cycles per column slot; must be ≥ 4.
- `DEBOUNCE_FRAMES`, 4: consecutive identical full frames required to accept a press, and empty frames required to accept a release; must be ≥ 1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col`  out  4  column drive, active-low, exactly one bit low at any time.
- `key_en`  out  1  one-cycle pulse per accepted key press.
- `key_code`  out  4  code of the last accepted key; valid when `key_en` is high and held stable until the next `key_en`.
- `key_held`  out  1  high from the `key_en` cycle until the release is accepted.

## Operation
- **Row synchronization:** `row` passes through a 2-flop synchronizer before any use.
- **Column stepping:**
  - `col_idx` runs 0→3 and wraps.
  - `col = ~(4'b0001 << col_idx)`.
  - A slot lasts `SCAN_DIV` cycles.
  - In the last cycle of each slot, the synchronized rows are sampled for the current column, then `col_idx` advances.
- **Frame:** 4 slots. In the last cycle of slot 3 (the frame end), the frame result is classified:
  - NONE: 0 keys pressed.
  - SINGLE(k): exactly 1 key pressed.
  - MULTI: 2 or more keys pressed; treated as invalid.
- **Key map (row r, col c):**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **FSM (evaluated only at frame end; all states otherwise hold):**
  - IDLE
    - SINGLE(k) → DEBOUNCE, with `cand = k`, `cnt = 1`.
    - Otherwise stay.
  - DEBOUNCE
    - SINGLE(cand) → `cnt++`. When `cnt` reaches `DEBOUNCE_FRAMES`: `key_code <= cand`, pulse `key_en`, go to HELD, `cnt = 0`.
    - NONE / MULTI / SINGLE(other) → IDLE, `cnt = 0`.
    - With `DEBOUNCE_FRAMES = 1`, the IDLE frame that sees SINGLE(k) accepts immediately.
  - HELD
    - NONE → `cnt++`. When `cnt` reaches `DEBOUNCE_FRAMES` → IDLE.
    - SINGLE / MULTI → `cnt = 0` and stay.
    - No auto-repeat. A different key pressed while held is ignored until a full release.
- **Counter width:** `cnt` is wide enough for `DEBOUNCE_FRAMES` and saturates; it never wraps.

## Timing
- **Reset values:**
  - `col = 4'b1110` (`col_idx = 0`)
  - `key_en = 0`, `key_code = 0`, `key_held = 0`
  - FSM in IDLE, slot timer 0, synchronizer flops 1 (released).
- **Reset mid-operation:** any in-progress debounce or held key is discarded. No `key_en` is issued for it.
- **Latency:**
  - `key_en` is registered and asserts in the cycle after the frame-end cycle that completes the debounce.
  - `key_held` rises in the same cycle as `key_en`.
  - `key_held` falls in the cycle after the frame end that completes the release.
- **Settling:**
  - Row data reaching the sampler in a slot's last cycle reflects the column drive from at least `SCAN_DIV − 3` cycles earlier.
  - This is why `SCAN_DIV ≥ 4` is required.
- **Worst-case press-to-`key_en`:** `(DEBOUNCE_FRAMES + 1) × 4 × SCAN_DIV + 3` cycles.
- **Output spacing:** `key_en` is never high in two consecutive cycles. Accepted keys are at least `(2×DEBOUNCE_FRAMES) × 4 × SCAN_DIV` cycles apart.

## Structure
- **Package `keypad_pkg`:**
  - state enum (IDLE, DEBOUNCE, HELD)
  - 16-entry key-map constant, indexed `{row, col}`
  - frame-result enum (NONE, SINGLE, MULTI)
- **Sub-module `scan_timer`:**
  - synchronous-reset slot counter, modulo `SCAN_DIV`
  - outputs `slot_end` and the 2-bit `col_idx`
  - `frame_end = slot_end && col_idx == 3`
- **Top level (`keypad_scan`):** synchronizer, per-frame row accumulation (4×4 bit matrix), classification, FSM, output registers.

## Test plan
Bench parameters: `SCAN_DIV = 4`, `DEBOUNCE_FRAMES = 2`, so a frame is 16 cycles. A keypad model pulls row r low while col c is low and key (r,c) is pressed.

- **Single clean press:** press (1,1) from reset, held for 5 frames → exactly one `key_en` pulse with `key_code = 5`, asserted the cycle after the 2nd qualifying frame end; `key_held = 1` until 2 empty frames after release.
- **Bounce:** press (3,1) for 1 frame, release for 1 frame, then hold for 3 frames → exactly one `key_en` with `key_code = 0`, with no pulse from the first contact.
- **Ghost/multi-key:** hold (0,0) and (0,1) together for 6 frames → no `key_en`, `key_held = 0`. Release (0,1) while keeping (0,0) → `key_code = 1` after 2 frames.
- **Held, no repeat:** hold (2,3) for 20 frames → one `key_en`, `key_code = C`. Press (0,3) additionally mid-hold → no new pulse until both are released for 2 frames.
- **Release glitch:** after acceptance, release for 1 frame, press again for 1 frame, release for 2 frames → no second `key_en`, `key_held` stays high until the final 2-frame release.
- **Reset mid-debounce:** assert `rst` one cycle after the first qualifying frame end → all outputs at reset values, `col = 1110` the cycle after, and no `key_en` until a full new debounce of 2 frames.
